// File: rtl/alu_req_fifo_pkg.sv
// Shared ALU op codes, op-class and funct constants.
// Used by the request FIFO and the single-cycle datapath decoder.
package alu_req_fifo_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_AND     = 4'b0000;
  localparam alu_op_t OP_OR      = 4'b0001;
  localparam alu_op_t OP_ADD     = 4'b0010;
  localparam alu_op_t OP_SUB     = 4'b0110;
  localparam alu_op_t OP_SLT     = 4'b0111;
  localparam alu_op_t OP_NOR     = 4'b1100;
  localparam alu_op_t OP_ILLEGAL = 4'b1111;

  localparam logic [1:0] CLS_MEM    = 2'b00;
  localparam logic [1:0] CLS_BRANCH = 2'b01;
  localparam logic [1:0] CLS_RTYPE  = 2'b10;
  localparam logic [1:0] CLS_RSVD   = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_op_decode.sv
// Op-class/funct to 4-bit ALU op translation (combinational).
// Ports: alu_op, funct in; op, illegal out.
module alu_op_decode
  import alu_req_fifo_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_op_t    op,
  output logic       illegal
);

  always_comb begin
    op      = OP_ILLEGAL;
    illegal = 1'b1;
    unique case (alu_op)
      CLS_MEM: begin
        op      = OP_ADD;
        illegal = 1'b0;
      end
      CLS_BRANCH: begin
        op      = OP_SUB;
        illegal = 1'b0;
      end
      CLS_RTYPE: begin
        illegal = 1'b0;
        unique case (funct)
          FN_ADD:  op = OP_ADD;
          FN_SUB:  op = OP_SUB;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_NOR:  op = OP_NOR;
          FN_SLT:  op = OP_SLT;
          default: begin
            op      = OP_ILLEGAL;
            illegal = 1'b1;
          end
        endcase
      end
      CLS_RSVD: begin
        op      = OP_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_req_fifo.sv
// Decode-to-ALU request FIFO: translates op class/funct at push,
// queues {op, illegal, rs1, rs2}, presents head under valid/ready.
// Ports: clk, rst; in_valid/in_ready/in_alu_op/in_funct/in_rs1/in_rs2;
// out_valid/out_ready/out_op/out_rs1/out_rs2/out_illegal;
// count, illegal_seen, clr_illegal.
module alu_req_fifo
  import alu_req_fifo_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_alu_op,
  input  logic [5:0]               in_funct,
  input  logic [DWIDTH-1:0]        in_rs1,
  input  logic [DWIDTH-1:0]        in_rs2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_op,
  output logic [DWIDTH-1:0]        out_rs1,
  output logic [DWIDTH-1:0]        out_rs2,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal_seen,
  input  logic                     clr_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  alu_op_t           mem_op  [DEPTH];
  logic              mem_ill [DEPTH];
  logic [DWIDTH-1:0] mem_rs1 [DEPTH];
  logic [DWIDTH-1:0] mem_rs2 [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  alu_op_t       dec_op;
  logic          dec_ill;
  logic          push;
  logic          pop;

  alu_op_decode u_dec (
    .alu_op  (in_alu_op),
    .funct   (in_funct),
    .op      (dec_op),
    .illegal (dec_ill)
  );

  // in_ready depends only on registered count, so a pop
  // never frees a slot for a push in the same cycle.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_op      = out_valid ? mem_op[rd_ptr]  : '0;
  assign out_illegal = out_valid ? mem_ill[rd_ptr] : 1'b0;
  assign out_rs1     = out_valid ? mem_rs1[rd_ptr] : '0;
  assign out_rs2     = out_valid ? mem_rs2[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr]  <= dec_op;
      mem_ill[wr_ptr] <= dec_ill;
      mem_rs1[wr_ptr] <= in_rs1;
      mem_rs2[wr_ptr] <= in_rs2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      illegal_seen <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (push && dec_ill)
        illegal_seen <= 1'b1;
      else if (clr_illegal)
        illegal_seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_req_fifo.sv
// Randomized + directed bench for alu_req_fifo against
// a queue-based reference model.
module tb_alu_req_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]    op;
    logic          ill;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_alu_op = '0;
  logic [5:0]    in_funct = '0;
  logic [DW-1:0] in_rs1 = '0;
  logic [DW-1:0] in_rs2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_op;
  logic [DW-1:0] out_rs1;
  logic [DW-1:0] out_rs2;
  logic          out_illegal;
  logic [2:0]    count;
  logic          illegal_seen;
  logic          clr_illegal = 1'b0;

  ent_t q[$];
  logic m_seen = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  alu_req_fifo #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_alu_op    (in_alu_op),
    .in_funct     (in_funct),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op       (out_op),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_illegal  (out_illegal),
    .count        (count),
    .illegal_seen (illegal_seen),
    .clr_illegal  (clr_illegal)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [4:0] xlate(input logic [1:0] cls,
                                       input logic [5:0] fn);
    if (cls == 2'd0) return {1'b0, 4'b0010};
    if (cls == 2'd1) return {1'b0, 4'b0110};
    if (cls == 2'd3) return {1'b1, 4'b1111};
    case (fn)
      6'd32:   return {1'b0, 4'b0010};
      6'd34:   return {1'b0, 4'b0110};
      6'd36:   return {1'b0, 4'b0000};
      6'd37:   return {1'b0, 4'b0001};
      6'd39:   return {1'b0, 4'b1100};
      6'd42:   return {1'b0, 4'b0111};
      default: return {1'b1, 4'b1111};
    endcase
  endfunction

  task automatic check_model(input string ctx);
    chk({ctx, "_count"}, 64'(count), 64'(q.size()));
    chk({ctx, "_in_ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
    chk({ctx, "_out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({ctx, "_seen"}, 64'(illegal_seen), 64'(m_seen));
    if (q.size() > 0) begin
      chk({ctx, "_op"}, 64'(out_op), 64'(q[0].op));
      chk({ctx, "_ill"}, 64'(out_illegal), 64'(q[0].ill));
      chk({ctx, "_rs1"}, 64'(out_rs1), 64'(q[0].a));
      chk({ctx, "_rs2"}, 64'(out_rs2), 64'(q[0].b));
    end else begin
      chk({ctx, "_idle_out"},
          {27'd0, out_illegal, out_op, out_rs1}, 64'd0);
      chk({ctx, "_idle_rs2"}, 64'(out_rs2), 64'd0);
    end
  endtask

  task automatic step(input logic iv, input logic [1:0] cls,
                      input logic [5:0] fn, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic ordy,
                      input logic clr, input string ctx);
    bit   acc, pd;
    ent_t e;
    logic [4:0] t;
    in_valid    = iv;
    in_alu_op   = cls;
    in_funct    = fn;
    in_rs1      = a;
    in_rs2      = b;
    out_ready   = ordy;
    clr_illegal = clr;
    @(negedge clk);
    check_model(ctx);
    acc = iv && (q.size() < DEPTH);
    pd  = ordy && (q.size() > 0);
    t   = xlate(cls, fn);
    e.op = t[3:0];
    e.ill = t[4];
    e.a = a;
    e.b = b;
    @(posedge clk);
    if (pd) void'(q.pop_front());
    if (acc) q.push_back(e);
    if (acc && e.ill) m_seen = 1'b1;
    else if (clr) m_seen = 1'b0;
    #1;
  endtask

  task automatic idle(input string ctx);
    step(1'b0, 2'd0, 6'd0, '0, '0, 1'b0, 1'b0, ctx);
  endtask

  initial begin
    logic [5:0] fns [8];
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd63};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    idle("post_rst");

    step(1'b1, 2'd2, 6'd36, 32'h0F0F, 32'h00FF, 1'b0, 1'b0, "and_push");
    chk("and_op", 64'(out_op), 64'h0);
    chk("and_rs1", 64'(out_rs1), 64'h0F0F);
    chk("and_rs2", 64'(out_rs2), 64'h00FF);
    chk("and_count", 64'(count), 64'd1);
    step(1'b0, 2'd0, 6'd0, '0, '0, 1'b1, 1'b0, "and_pop");

    for (int i = 1; i <= 5; i++)
      step(1'b1, 2'd0, 6'd0, DW'(i), DW'(i * 7), 1'b0, 1'b0, "fill");
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 2'd1, 6'd0, 32'h99, 32'h99, 1'b1, 1'b0, "full_pp");
    chk("full_pp_count", 64'(count), 64'd3);
    chk("full_pp_ready", 64'(in_ready), 64'd1);
    chk("full_pp_head", 64'(out_rs1), 64'd2);
    step(1'b0, 2'd0, 6'd0, '0, '0, 1'b1, 1'b0, "drain1");
    chk("at2_count", 64'(count), 64'd2);

    for (int i = 1; i <= 10; i++)
      step(1'b1, 2'd2, 6'd42, DW'(i), DW'(100 + i), 1'b1, 1'b0, "pp");
    chk("pp_count", 64'(count), 64'd2);
    chk("pp_head", 64'(out_rs1), 64'd9);
    repeat (3) step(1'b0, 2'd0, 6'd0, '0, '0, 1'b1, 1'b0, "drain2");

    step(1'b1, 2'd2, 6'd0, 32'h5, 32'h6, 1'b0, 1'b0, "ill_push");
    chk("ill_op", 64'(out_op), 64'hF);
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_seen", 64'(illegal_seen), 64'd1);
    step(1'b1, 2'd3, 6'd0, 32'h7, 32'h8, 1'b1, 1'b1, "ill_clr_set");
    chk("set_wins", 64'(illegal_seen), 64'd1);
    step(1'b0, 2'd0, 6'd0, '0, '0, 1'b1, 1'b1, "clr_only");
    chk("clr_seen", 64'(illegal_seen), 64'd0);
    idle("post_clr");

    for (int i = 0; i < 3; i++)
      step(1'b1, 2'd2, 6'd37, DW'(i + 40), DW'(i), 1'b0, 1'b0, "pre_rst");
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_illegal = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_rs1", 64'(out_rs1), 64'd0);
    q.delete();
    m_seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 2'd2, 6'd39, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0, "post_rst_push");
    chk("post_rst_op", 64'(out_op), 64'hC);
    chk("post_rst_rs1", 64'(out_rs1), 64'hAAAA);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           fns[$urandom_range(0, 7)],
           $urandom, $urandom,
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 7) == 0), "rnd");
    idle("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_req_fifo.md
Name: alu_req_fifo

Overview:
- Request buffer directly upstream of the ALU.
- Accepts decode-stage requests: 2-bit ALU-op class, 6-bit MIPS funct, two signed operands.
- Translates class/funct into the ALU's 4-bit op code and queues the translated request in a small FIFO.
- Presents the head entry to the ALU inputs under a valid/ready handshake, so decode and execute are decoupled.

Parameters:
- DWIDTH, 32, operand width; matches the ALU data width.
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  FIFO can accept; equals !full.
- in_alu_op  input  2  op class: 00 load/store, 01 branch, 10 R-type, 11 reserved.
- in_funct  input  6  R-type funct field; used only when in_alu_op=10.
- in_rs1  input  DWIDTH  signed operand 1.
- in_rs2  input  DWIDTH  signed operand 2.
- out_valid  output  1  head entry valid (FIFO not empty).
- out_ready  input  1  ALU side consumes head.
- out_op  output  4  translated ALU op of head entry.
- out_rs1  output  DWIDTH  head operand 1.
- out_rs2  output  DWIDTH  head operand 2.
- out_illegal  output  1  head entry came from an untranslatable request.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- illegal_seen  output  1  sticky: an illegal request was accepted.
- clr_illegal  input  1  synchronous clear of illegal_seen.

Behaviour:
- Translation (combinational, at push):
  - alu_op=00 → ADD 0010.
  - alu_op=01 → SUB 0110.
  - alu_op=10 with funct 100000 → ADD 0010.
  - alu_op=10 with funct 100010 → SUB 0110.
  - alu_op=10 with funct 100100 → AND 0000.
  - alu_op=10 with funct 100101 → OR 0001.
  - alu_op=10 with funct 100111 → NOR 1100.
  - alu_op=10 with funct 101010 → SLT 0111.
  - Any other alu_op=10 funct, or alu_op=11 → op 1111, illegal=1.
  - Illegal requests are still enqueued, never dropped.
- Push: in_valid && in_ready. Write {op, illegal, rs1, rs2} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready. rd_ptr increments modulo DEPTH.
- count update per cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Full (count=DEPTH):
  - in_ready=0; in_valid is ignored.
  - No push-through, even if a pop occurs in the same cycle; in_ready recovers the cycle after the pop.
- Empty (count=0):
  - out_valid=0.
  - out_op, out_rs1, out_rs2, out_illegal driven 0.
  - out_ready is ignored.
- Latency:
  - No combinational bypass.
  - A push into an empty FIFO appears on out_* with out_valid=1 on the next cycle.
- Stability: out_* hold their value while out_valid=1 and out_ready=0.
- illegal_seen:
  - Set on any accepted push with illegal=1.
  - Cleared by clr_illegal.
  - If set and clear happen in the same cycle, set wins.
- Reset (asynchronous, any time including mid-transfer):
  - wr_ptr=0, rd_ptr=0, count=0, illegal_seen=0.
  - out_valid=0, all out_* =0, in_ready=1.
  - Storage contents need not be cleared.
- Pointer widths are $clog2(DEPTH); wrap is natural overflow. count carries one extra bit to encode DEPTH.

Decomposition:
- Shared package holds:
  - ALU op localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLT, OP_ILLEGAL=1111.
  - ALU-op class constants.
  - Funct constants.
- One combinational sub-module, alu_op_decode: in_alu_op, in_funct → op, illegal. It is reusable by the single-cycle datapath.

Test Plan:
- Reset, then push alu_op=10, funct=100100, rs1=0x0F0F, rs2=0x00FF → next cycle out_valid=1, out_op=0000, out_rs1=0x0F0F, out_rs2=0x00FF, count=1.
- Push 4 requests with out_ready=0 → count=4, in_ready=0; fifth push ignored. Pop one → in_ready=1 next cycle; entries emerge in push order.
- Hold full and drive push+pop in the same cycle → no push accepted, count 4→3.
- At count=2, push+pop in the same cycle → count stays 2. Run 10 cycles of push+pop → wrap-around preserves order, verified via rs1 sequence numbers 1..10.
- Push alu_op=10, funct=000000 → out_op=1111, out_illegal=1, illegal_seen=1. Assert clr_illegal with another illegal push in the same cycle → illegal_seen stays 1. Assert clr_illegal alone → 0.
- Assert rst with 3 entries queued, mid-cycle → immediately out_valid=0, count=0, in_ready=1. After release, first push appears with correct data.
